wrr_prio_table: RTL and testbench
=================================

// Module: wrr_prio_table
// PURPOSE
//  Receive side of the priority-update interface (prio_upt/prio_id/prio) for the weighted round robin arbiter.
//  - Stages per-requester priority (weight) writes in a shadow table.
//  - Commits staged writes atomically at arbitration round boundaries.
//  - Keeps one credit counter per requester, reloaded from the committed weight.
//  - The arbiter consumes credits on each grant and reads the credit-nonzero mask.
// PARAMETERS
//  N_REQ         32  number of requesters / table entries (<= 2**ID_W)
//  PRIO_W        4   weight width; weight 0 = requester disabled
//  ID_W          5   requester id width
//  DEFAULT_PRIO  1   committed weight and credit value after reset
// PORTS
//  clk          in   1             single clock, all state on posedge
//  rst          in   1             asynchronous, active-high reset
//  prio_upt     in   1             update strobe, one write per cycle
//  prio_id      in   ID_W          requester id targeted by the update
//  prio         in   PRIO_W        new weight for prio_id
//  round_end    in   1             one-cycle pulse from arbiter: commit staged weights and reload credits
//  grant_vld    in   1             arbiter granted grant_id this cycle
//  grant_id     in   ID_W          granted requester id
//  prio_active  out  N_REQ*PRIO_W  committed weights, entry i at [i*PRIO_W +: PRIO_W]
//  credit_nz    out  N_REQ         bit i = credit[i] != 0
//  upt_pending  out  1             at least one staged, uncommitted update exists
//  err_cnt      out  8             count of rejected updates (prio_id >= N_REQ), saturates at 255
// BEHAVIOUR
//  Reset (async assert, synchronous-to-clk release):
//  - shadow[i] = active[i] = credit[i] = DEFAULT_PRIO for every i.
//  - pending = 0, err_cnt = 0, upt_pending = 0.
//  - credit_nz = all ones if DEFAULT_PRIO != 0, otherwise all zeros.
//  Update path (posedge with prio_upt = 1):
//  - Valid id (prio_id < N_REQ): shadow[prio_id] <= prio and pending[prio_id] <= 1.
//  - Invalid id (prio_id >= N_REQ): no table change; err_cnt += 1, saturating at 255.
//  - Repeated updates to the same id before a commit: the last write wins.
//  - active, credit and prio_active are untouched until a commit.
//  Commit (posedge with round_end = 1):
//  - For every i with pending[i] = 1: active[i] <= shadow[i]. Other entries keep their value.
//  - For every i: credit[i] <= the new active[i], i.e. the post-commit value.
//  - pending <= 0.
//  - The result is visible on prio_active and credit_nz in the cycle after the round_end edge.
//  Grant (posedge with grant_vld = 1, grant_id < N_REQ):
//  - credit[grant_id] -= 1, saturating at 0; no underflow.
//  - grant_id >= N_REQ: ignored; err_cnt is not changed.
//  - credit_nz updates one cycle after the grant edge.
//  Simultaneous events in the same cycle:
//  - prio_upt + round_end: the commit uses the shadow contents from before this edge. The new write lands in shadow, and its pending bit ends set (set wins over clear). It applies at the next round_end.
//  - grant_vld + round_end: reload wins; the grant is not deducted from the reloaded credit.
//  - prio_upt + grant_vld to the same id: independent. Shadow is written and credit is decremented.
//  Weight 0:
//  - The committed credit is 0 and credit_nz[i] = 0 until a nonzero weight is committed.
//  - Grants to a disabled id are no-ops.
//  Reset mid-operation: all staged updates, pending bits and credits are discarded and the reset values are restored immediately.
//  Outputs prio_active, credit_nz, upt_pending and err_cnt are registered or direct register decodes; no input-to-output combinational path.
// TESTING
//  1. Reset then idle -> prio_active is all 4'h1, credit_nz = 32'hFFFF_FFFF, upt_pending = 0, err_cnt = 0.
//  2. prio_upt with id 3, prio 5; no round_end for 10 cycles -> active[3] stays 1 and upt_pending = 1. Then pulse round_end -> next cycle active[3] = 5, credit[3] = 5, upt_pending = 0.
//  3. Commit weight 3 to id 7, then 4 grants to id 7 -> credit_nz[7] drops to 0 after the 3rd grant and stays 0 after the 4th (no wrap).
//  4. prio_upt with id 9, prio 6 in the same cycle as round_end -> active[9] stays 1 and upt_pending = 1. The next round_end sets active[9] = 6.
//  5. prio_upt with id 31, prio 0, then round_end -> credit_nz[31] = 0. Any grant to id 31 leaves all counters unchanged.
//  6. 300 updates with prio_id >= N_REQ (N_REQ = 20, id 25) -> err_cnt saturates at 255 and the table is unchanged. Assert rst mid-burst -> err_cnt = 0 immediately.

Source files
------------

// File: rtl/wrr_prio_if.sv
// wrr_prio_if: priority-update, commit and grant signals between the WRR arbiter and its weight table.
interface wrr_prio_if #(
    parameter int N_REQ  = 32,
    parameter int PRIO_W = 4,
    parameter int ID_W   = 5
);
    logic                    prio_upt;
    logic [ID_W-1:0]         prio_id;
    logic [PRIO_W-1:0]       prio;
    logic                    round_end;
    logic                    grant_vld;
    logic [ID_W-1:0]         grant_id;
    logic [N_REQ*PRIO_W-1:0] prio_active;
    logic [N_REQ-1:0]        credit_nz;
    logic                    upt_pending;
    logic [7:0]              err_cnt;
    modport master (
        output prio_upt, prio_id, prio, round_end, grant_vld, grant_id,
        input  prio_active, credit_nz, upt_pending, err_cnt
    );
    modport slave (
        input  prio_upt, prio_id, prio, round_end, grant_vld, grant_id,
        output prio_active, credit_nz, upt_pending, err_cnt
    );
endinterface

// File: rtl/wrr_prio_table.sv
// wrr_prio_table: shadow/committed weight table with per-requester credit counters for a WRR arbiter.
module wrr_prio_table #(
    parameter int N_REQ        = 32,
    parameter int PRIO_W       = 4,
    parameter int ID_W         = 5,
    parameter int DEFAULT_PRIO = 1
) (
    input logic        clk,
    input logic        rst,
    wrr_prio_if.slave  bus
);
    localparam logic [ID_W:0]     N_LIM = (ID_W+1)'(N_REQ);
    localparam logic [PRIO_W-1:0] DEF   = PRIO_W'(DEFAULT_PRIO);
    logic [PRIO_W-1:0] shadow [N_REQ];
    logic [PRIO_W-1:0] active [N_REQ];
    logic [PRIO_W-1:0] credit [N_REQ];
    logic [N_REQ-1:0]  pending;
    logic [7:0]        err_q;
    logic              upt_ok;
    logic              gnt_ok;
    logic              upt_bad;
    assign upt_ok  = bus.prio_upt && ({1'b0, bus.prio_id} < N_LIM);
    assign upt_bad = bus.prio_upt && !({1'b0, bus.prio_id} < N_LIM);
    assign gnt_ok  = bus.grant_vld && ({1'b0, bus.grant_id} < N_LIM);
    // Commit reads pre-edge shadow/pending, so a same-cycle write lands for the next round.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_REQ; i++) begin
                shadow[i] <= DEF;
                active[i] <= DEF;
                credit[i] <= DEF;
            end
            pending <= '0;
            err_q   <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (upt_ok && bus.prio_id == ID_W'(i))
                    shadow[i] <= bus.prio;
                if (bus.round_end && pending[i])
                    active[i] <= shadow[i];
                if (bus.round_end)
                    credit[i] <= pending[i] ? shadow[i] : active[i];
                else if (gnt_ok && bus.grant_id == ID_W'(i) && credit[i] != '0)
                    credit[i] <= credit[i] - 1'b1;
                pending[i] <= (upt_ok && bus.prio_id == ID_W'(i)) ? 1'b1 :
                              bus.round_end ? 1'b0 : pending[i];
            end
            if (upt_bad && err_q != 8'hFF)
                err_q <= err_q + 8'd1;
        end
    end
    for (genvar g = 0; g < N_REQ; g++) begin : g_out
        assign bus.prio_active[g*PRIO_W +: PRIO_W] = active[g];
        assign bus.credit_nz[g] = |credit[g];
    end
    assign bus.upt_pending = |pending;
    assign bus.err_cnt     = err_q;
endmodule

// File: tb/tb_wrr_prio_table.sv
// tb_wrr_prio_table: directed vector table plus hand sequences for the WRR weight/credit table.
module tb_wrr_prio_table;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    always #5 clk = ~clk;
    wrr_prio_if #(.N_REQ(32), .PRIO_W(4), .ID_W(5)) a ();
    wrr_prio_if #(.N_REQ(20), .PRIO_W(4), .ID_W(5)) b ();
    wrr_prio_table #(.N_REQ(32), .PRIO_W(4), .ID_W(5), .DEFAULT_PRIO(1)) dut_a (.clk(clk), .rst(rst), .bus(a));
    wrr_prio_table #(.N_REQ(20), .PRIO_W(4), .ID_W(5), .DEFAULT_PRIO(1)) dut_b (.clk(clk), .rst(rst), .bus(b));
    typedef struct {
        logic       upt;
        logic [4:0] id;
        logic [3:0] pr;
        logic       re;
        logic       gv;
        logic [4:0] gid;
        int         chk;
        logic [3:0] e_act;
        logic       e_nz;
        logic       e_pend;
    } vec_t;
    vec_t vecs[24];
    logic [127:0] exp_a;
    logic [79:0]  exp_b;
    function automatic vec_t mk(logic upt, logic [4:0] id, logic [3:0] pr, logic re, logic gv,
                                logic [4:0] gid, int chk, logic [3:0] e_act, logic e_nz, logic e_pend);
        mk = '{upt, id, pr, re, gv, gid, chk, e_act, e_nz, e_pend};
    endfunction
    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic idle;
        a.prio_upt = 0; a.prio_id = 0; a.prio = 0; a.round_end = 0; a.grant_vld = 0; a.grant_id = 0;
        b.prio_upt = 0; b.prio_id = 0; b.prio = 0; b.round_end = 0; b.grant_vld = 0; b.grant_id = 0;
    endtask
    initial begin
        idle();
        repeat (2) @(posedge clk);
        #1 rst = 0;
        check("rst_active", a.prio_active, {32{4'h1}});
        check("rst_nz", a.credit_nz, 32'hFFFF_FFFF);
        check("rst_pend", a.upt_pending, 0);
        check("rst_err", a.err_cnt, 0);
        // staged write held for 10 cycles, then committed
        a.prio_upt = 1; a.prio_id = 3; a.prio = 5;
        tick();
        idle();
        repeat (10) tick();
        check("hold_active3", a.prio_active[12 +: 4], 4'h1);
        check("hold_pend", a.upt_pending, 1);
        a.round_end = 1;
        tick();
        idle();
        check("commit_active3", a.prio_active[12 +: 4], 4'h5);
        check("commit_pend", a.upt_pending, 0);
        vecs[0]  = mk(0, 0, 0, 0, 1, 3, 3, 5, 1, 0);
        vecs[1]  = mk(0, 0, 0, 0, 1, 3, 3, 5, 1, 0);
        vecs[2]  = mk(0, 0, 0, 0, 1, 3, 3, 5, 1, 0);
        vecs[3]  = mk(0, 0, 0, 0, 1, 3, 3, 5, 1, 0);
        vecs[4]  = mk(0, 0, 0, 0, 1, 3, 3, 5, 0, 0);
        vecs[5]  = mk(1, 7, 3, 0, 0, 0, 7, 1, 1, 1);
        vecs[6]  = mk(0, 0, 0, 1, 0, 0, 7, 3, 1, 0);
        vecs[7]  = mk(0, 0, 0, 0, 1, 7, 7, 3, 1, 0);
        vecs[8]  = mk(0, 0, 0, 0, 1, 7, 7, 3, 1, 0);
        vecs[9]  = mk(0, 0, 0, 0, 1, 7, 7, 3, 0, 0);
        vecs[10] = mk(0, 0, 0, 0, 1, 7, 7, 3, 0, 0);
        vecs[11] = mk(1, 9, 6, 1, 0, 0, 9, 1, 1, 1);
        vecs[12] = mk(0, 0, 0, 0, 0, 0, 9, 1, 1, 1);
        vecs[13] = mk(0, 0, 0, 1, 0, 0, 9, 6, 1, 0);
        vecs[14] = mk(0, 0, 0, 0, 0, 0, 7, 3, 1, 0);
        vecs[15] = mk(1, 31, 0, 0, 0, 0, 31, 1, 1, 1);
        vecs[16] = mk(0, 0, 0, 1, 0, 0, 31, 0, 0, 0);
        vecs[17] = mk(0, 0, 0, 0, 1, 31, 31, 0, 0, 0);
        vecs[18] = mk(0, 0, 0, 1, 1, 2, 2, 1, 1, 0);
        vecs[19] = mk(1, 2, 4, 0, 1, 2, 2, 1, 0, 1);
        vecs[20] = mk(0, 0, 0, 1, 0, 0, 2, 4, 1, 0);
        vecs[21] = mk(1, 5, 2, 0, 0, 0, 5, 1, 1, 1);
        vecs[22] = mk(1, 5, 7, 0, 0, 0, 5, 1, 1, 1);
        vecs[23] = mk(0, 0, 0, 1, 0, 0, 5, 7, 1, 0);
        for (int i = 0; i < 24; i++) begin
            a.prio_upt = vecs[i].upt; a.prio_id = vecs[i].id; a.prio = vecs[i].pr;
            a.round_end = vecs[i].re; a.grant_vld = vecs[i].gv; a.grant_id = vecs[i].gid;
            tick();
            check($sformatf("v%0d_active", i), a.prio_active[vecs[i].chk*4 +: 4], vecs[i].e_act);
            check($sformatf("v%0d_nz", i), a.credit_nz[vecs[i].chk], vecs[i].e_nz);
            check($sformatf("v%0d_pend", i), a.upt_pending, vecs[i].e_pend);
            if (i == 17) check("grant31_all_nz", a.credit_nz, 32'h7FFF_FFFF);
        end
        idle();
        exp_a = {32{4'h1}};
        exp_a[3*4 +: 4] = 4'h5; exp_a[7*4 +: 4] = 4'h3; exp_a[9*4 +: 4] = 4'h6;
        exp_a[31*4 +: 4] = 4'h0; exp_a[2*4 +: 4] = 4'h4; exp_a[5*4 +: 4] = 4'h7;
        check("final_active", a.prio_active, exp_a);
        check("final_nz", a.credit_nz, 32'h7FFF_FFFF);
        check("final_err_a", a.err_cnt, 0);
        // invalid ids on the 20-entry table
        b.grant_vld = 1; b.grant_id = 25;
        tick();
        idle();
        check("bad_grant_err", b.err_cnt, 0);
        check("bad_grant_nz", b.credit_nz, 20'hFFFFF);
        b.prio_upt = 1; b.prio_id = 25; b.prio = 9;
        repeat (100) tick();
        check("err_100", b.err_cnt, 100);
        repeat (200) tick();
        check("err_sat", b.err_cnt, 255);
        exp_b = {20{4'h1}};
        check("bad_upt_table", b.prio_active, exp_b);
        check("bad_upt_pend", b.upt_pending, 0);
        repeat (10) tick();
        #3 rst = 1;
        #1;
        check("async_rst_err", b.err_cnt, 0);
        check("async_rst_a", a.prio_active, {32{4'h1}});
        check("async_rst_nz_a", a.credit_nz, 32'hFFFF_FFFF);
        idle();
        tick();
        rst = 0;
        tick();
        check("post_rst_err", b.err_cnt, 0);
        check("post_rst_pend", a.upt_pending, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
